padlock_cracker: RTL

- Brute-force code-entry driver: the transmit end of the padlock button interface.
- Drives one-hot button strobes and a padlock reset into a 4-digit, 2-bit-per-digit padlock, and watches the padlock's lock output.
- Walks all 256 candidate codes until one unlocks, then reports it.
- Sits beside the padlock in the security test harness; used for bring-up and for exhaustive-search demos.

---
 rtl/padlock_cracker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/padlock_cracker.sv
// Brute-force code-entry driver for a 4-digit, 2-bit-per-digit padlock.
// Walks candidates 0..255, confirms each apparent hit after a padlock reset, and reports the code or exhaustion.
module padlock_cracker #(
  parameter int PRESS_GAP = 1,
  parameter int SETTLE    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       lock,
  output logic       pad_reset,
  output logic       but_0,
  output logic       but_1,
  output logic       but_2,
  output logic       but_3,
  output logic       busy,
  output logic       found,
  output logic       exhausted,
  output logic [7:0] code_out
);

  typedef enum logic [3:0] {
    IDLE,
    RST_PAD,
    PRESS,
    GAP,
    SETTLE_W,
    CHECK,
    CONF_RST,
    CONF_W,
    CONF_CHK,
    DONE,
    EXH
  } state_t;

  localparam logic [15:0] GAP_LAST    = 16'((PRESS_GAP > 0) ? PRESS_GAP - 1 : 0);
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t      state_reg, state_next;
  logic [7:0]  cand_reg, cand_next;
  logic [1:0]  k_reg, k_next;
  logic [15:0] cnt_reg, cnt_next;

  logic        pad_reg, pad_next;
  logic [3:0]  but_reg, but_next;
  logic        busy_reg, busy_next;
  logic        found_reg, found_next;
  logic        exh_reg, exh_next;
  logic [7:0]  code_reg, code_next;

  logic        idle_like;
  logic        start_accept;
  logic [1:0]  digit;

  always_comb begin
    idle_like    = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == EXH);
    start_accept = idle_like && start;

    state_next = state_reg;
    cand_next  = cand_reg;
    k_next     = k_reg;
    cnt_next   = cnt_reg + 16'd1;

    case (state_reg)
      IDLE, DONE, EXH: begin
        if (start) begin
          cand_next  = 8'd0;
          state_next = RST_PAD;
        end
      end
      RST_PAD: begin
        k_next     = 2'd0;
        state_next = PRESS;
      end
      PRESS: begin
        if (PRESS_GAP > 0) begin
          state_next = GAP;
        end else if (k_reg == 2'd3) begin
          state_next = SETTLE_W;
        end else begin
          k_next = k_reg + 2'd1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          if (k_reg == 2'd3) begin
            state_next = SETTLE_W;
          end else begin
            k_next     = k_reg + 2'd1;
            state_next = PRESS;
          end
        end
      end
      SETTLE_W: begin
        if (cnt_reg == SETTLE_LAST) state_next = CHECK;
      end
      CHECK: begin
        if (!lock) begin
          state_next = CONF_RST;
        end else if (cand_reg == 8'hFF) begin
          state_next = EXH;
        end else begin
          cand_next  = cand_reg + 8'd1;
          state_next = RST_PAD;
        end
      end
      CONF_RST: begin
        state_next = CONF_W;
      end
      CONF_W: begin
        if (cnt_reg == SETTLE_LAST) state_next = CONF_CHK;
      end
      CONF_CHK: begin
        // A hit that does not survive a padlock reset was assembled from stale digits.
        if (!lock) begin
          state_next = DONE;
        end else if (cand_reg == 8'hFF) begin
          state_next = EXH;
        end else begin
          cand_next  = cand_reg + 8'd1;
          state_next = RST_PAD;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) cnt_next = 16'd0;
  end

  // Outputs are computed from the next state so the registered value matches the state in the same cycle.
  always_comb begin
    case (k_next)
      2'd0:    digit = cand_next[7:6];
      2'd1:    digit = cand_next[5:4];
      2'd2:    digit = cand_next[3:2];
      default: digit = cand_next[1:0];
    endcase

    pad_next = 1'b0;
    case (state_next)
      RST_PAD, CONF_RST: pad_next = 1'b1;
      IDLE, DONE, EXH:   pad_next = pad_reg;
      default:           pad_next = 1'b0;
    endcase

    but_next = 4'b0000;
    if (state_next == PRESS) but_next = 4'(4'b0001 << digit);

    busy_next = !((state_next == IDLE) || (state_next == DONE) || (state_next == EXH));

    found_next = found_reg;
    exh_next   = exh_reg;
    if (start_accept) begin
      found_next = 1'b0;
      exh_next   = 1'b0;
    end
    if (state_next == DONE) found_next = 1'b1;
    if (state_next == EXH)  exh_next   = 1'b1;

    code_next = (state_next == EXH) ? 8'hFF : cand_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cand_reg  <= 8'd0;
      k_reg     <= 2'd0;
      cnt_reg   <= 16'd0;
      pad_reg   <= 1'b1;
      but_reg   <= 4'b0000;
      busy_reg  <= 1'b0;
      found_reg <= 1'b0;
      exh_reg   <= 1'b0;
      code_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      k_reg     <= k_next;
      cnt_reg   <= cnt_next;
      pad_reg   <= pad_next;
      but_reg   <= but_next;
      busy_reg  <= busy_next;
      found_reg <= found_next;
      exh_reg   <= exh_next;
      code_reg  <= code_next;
    end
  end

  assign pad_reset = pad_reg;
  assign but_0     = but_reg[0];
  assign but_1     = but_reg[1];
  assign but_2     = but_reg[2];
  assign but_3     = but_reg[3];
  assign busy      = busy_reg;
  assign found     = found_reg;
  assign exhausted = exh_reg;
  assign code_out  = code_reg;

endmodule
